// File: rtl/seq_detector_moore_if.sv
// Serial-detector bundle: sample stream, pattern load and match results.
// master drives stimulus/control, slave (the detector) returns saida/contagem.
interface seq_detector_moore_if #(
  parameter int PATTERN_LEN = 4,
  parameter int CNT_W       = 8
);
  logic                   entrada;
  logic                   valid;
  logic [PATTERN_LEN-1:0] padrao;
  logic                   carregar;
  logic                   sobreposicao;
  logic                   saida;
  logic [CNT_W-1:0]       contagem;

  modport master (
    output entrada, valid, padrao, carregar, sobreposicao,
    input  saida, contagem
  );

  modport slave (
    input  entrada, valid, padrao, carregar, sobreposicao,
    output saida, contagem
  );
endinterface

// File: rtl/seq_detector_moore.sv
// Moore serial-pattern detector with KMP fallback, overlap control and saturating match count.
// One bit per valid clock, no stall; saida rises the cycle after the final pattern bit is sampled.
module seq_detector_moore #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PADRAO_RST  = 4'b1011,
  parameter int                     CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_moore_if.slave  s_if
);
  localparam int KW = $clog2(PATTERN_LEN + 1);

  typedef enum logic [KW-1:0] {
    S_IDLE  = KW'(0),
    S_MATCH = KW'(PATTERN_LEN)
  } state_t;

  state_t                 r_state;
  logic [PATTERN_LEN-1:0] r_pat;
  logic [PATTERN_LEN-1:0] r_hist;
  logic [KW-1:0]          r_fill;
  logic [CNT_W-1:0]       r_cnt;

  state_t                 w_state_nxt;
  logic [PATTERN_LEN-1:0] w_hist_shift;
  logic [PATTERN_LEN-1:0] w_mask;
  logic [KW-1:0]          w_fill_inc;
  logic                   w_hit;
  logic                   w_oob;
  int                     w_lim;

  // Next depth is the longest suffix of the accepted bits (bounded by fill) that is a prefix of r_pat.
  always_comb begin
    w_hist_shift = {r_hist[PATTERN_LEN-2:0], s_if.entrada};
    w_fill_inc   = (int'(r_fill) >= PATTERN_LEN) ? KW'(PATTERN_LEN) : r_fill + 1'b1;
    w_oob        = int'(r_state) > PATTERN_LEN;
    w_lim        = (int'(r_state) >= PATTERN_LEN) ? PATTERN_LEN : int'(r_state) + 1;
    w_mask       = '0;
    w_state_nxt  = S_IDLE;
    for (int j = 1; j <= PATTERN_LEN; j++) begin
      w_mask = {PATTERN_LEN{1'b1}} >> (PATTERN_LEN - j);
      if (j <= int'(w_fill_inc) && j <= w_lim &&
          ((w_hist_shift ^ (r_pat >> (PATTERN_LEN - j))) & w_mask) == '0) begin
        w_state_nxt = state_t'(KW'(j));
      end
    end
    w_hit = (w_state_nxt == S_MATCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= PADRAO_RST;
      r_state <= S_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else if (s_if.carregar) begin
      r_pat   <= s_if.padrao;
      r_state <= S_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else if (w_oob) begin
      r_state <= S_IDLE;
    end else if (s_if.valid) begin
      r_state <= w_state_nxt;
      // Non-overlapping: the matching edge is a restart point, older bits are forgotten.
      if (w_hit && !s_if.sobreposicao) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_shift;
        r_fill <= w_fill_inc;
      end
      if (w_hit && r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s_if.saida    = (r_state == S_MATCH);
  assign s_if.contagem = r_cnt;
endmodule

// File: tb/tb_seq_detector_moore.sv
// Bench for seq_detector_moore: directed scenarios plus random stream against a queue-based model.
// Two instances (CNT_W=8 and CNT_W=2) see identical stimulus so saturation is exercised throughout.
module tb_seq_detector_moore;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_moore_if #(.PATTERN_LEN(P), .CNT_W(8)) bus8 ();
  seq_detector_moore_if #(.PATTERN_LEN(P), .CNT_W(2)) bus2 ();

  assign bus2.entrada      = bus8.entrada;
  assign bus2.valid        = bus8.valid;
  assign bus2.padrao       = bus8.padrao;
  assign bus2.carregar     = bus8.carregar;
  assign bus2.sobreposicao = bus8.sobreposicao;

  seq_detector_moore #(.PATTERN_LEN(P), .PADRAO_RST(4'b1011), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .s_if (bus8.slave)
  );
  seq_detector_moore #(.PATTERN_LEN(P), .PADRAO_RST(4'b1011), .CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .s_if (bus2.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: accepted bits since the last restart, trimmed to the last P.
  logic [P-1:0] m_pat = 4'b1011;
  bit           m_q[$];
  int           m_k  = 0;
  int           m_c8 = 0;
  int           m_c2 = 0;

  function automatic int longest_prefix_suffix();
    int n;
    bit ok;
    n = m_q.size();
    for (int j = (n < P) ? n : P; j >= 1; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (m_q[n - j + i] != m_pat[P-1-i]) ok = 1'b0;
      end
      if (ok) return j;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pat = 4'b1011; m_q.delete(); m_k = 0; m_c8 = 0; m_c2 = 0;
    end else if (bus8.carregar) begin
      m_pat = bus8.padrao; m_q.delete(); m_k = 0; m_c8 = 0; m_c2 = 0;
    end else if (bus8.valid) begin
      m_q.push_back(bus8.entrada);
      if (m_q.size() > P) void'(m_q.pop_front());
      m_k = longest_prefix_suffix();
      if (m_k == P) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
        if (!bus8.sobreposicao) m_q.delete();
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("saida8", int'(bus8.saida), (m_k == P) ? 1 : 0);
      check("cnt8",   int'(bus8.contagem), m_c8);
      check("saida2", int'(bus2.saida), (m_k == P) ? 1 : 0);
      check("cnt2",   int'(bus2.contagem), m_c2);
    end
  end

  task automatic cyc(input bit r, input bit ld, input logic [P-1:0] pd,
                     input bit v, input bit b, input bit ov);
    rst               = r;
    bus8.carregar     = ld;
    bus8.padrao       = pd;
    bus8.valid        = v;
    bus8.entrada      = b;
    bus8.sobreposicao = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b, input bit ov);
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, b, ov);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] stream = 7'b1011011;
  bit         ov_r;

  initial begin
    bus8.carregar = 1'b0; bus8.padrao = '0; bus8.valid = 1'b0;
    bus8.entrada = 1'b0; bus8.sobreposicao = 1'b0;
    do_reset();
    do_reset();
    chk_en = 1'b1;
    check("rst_saida", int'(bus8.saida), 0);
    check("rst_cnt", int'(bus8.contagem), 0);

    // Overlapping run on 1011011
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i], 1'b1);
      if (i == 3) check("ov_bit4_saida", int'(bus8.saida), 1);
      if (i == 4) check("ov_bit5_saida", int'(bus8.saida), 0);
    end
    check("ov_bit7_saida", int'(bus8.saida), 1);
    check("ov_cnt", int'(bus8.contagem), 2);

    // Non-overlapping run on the same stream
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i], 1'b0);
      if (i == 3) check("nov_bit4_saida", int'(bus8.saida), 1);
    end
    check("nov_bit7_saida", int'(bus8.saida), 0);
    check("nov_cnt", int'(bus8.contagem), 1);

    // Self-overlapping pattern 1111
    cyc(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1);
      if (i >= 3) check("ones_ov_saida", int'(bus8.saida), 1);
    end
    check("ones_ov_cnt", int'(bus8.contagem), 2);
    cyc(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    check("ones_nov_saida", int'(bus8.saida), 0);
    check("ones_nov_cnt", int'(bus8.contagem), 1);

    // Valid gaps of 3 cycles between bits
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i], 1'b1);
      for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
      if (i == 3) check("gap_saida_held", int'(bus8.saida), 1);
    end
    check("gap_cnt", int'(bus8.contagem), 2);

    // Load wins over a simultaneous sample
    cyc(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1);
    check("ldv_cnt", int'(bus8.contagem), 0);
    send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
    check("ldv_nomatch_cnt", int'(bus8.contagem), 0);

    // Reset during a partial match at depth 3
    do_reset();
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("model_depth3", m_k, 3);
    do_reset();
    check("midrst_saida", int'(bus8.saida), 0);
    send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
    check("midrst_saida_after", int'(bus8.saida), 0);
    check("midrst_cnt", int'(bus8.contagem), 0);

    // Saturation: eight matches of 1111
    cyc(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) send(1'b1, 1'b1);
    check("sat_cnt8", int'(bus8.contagem), 8);
    check("sat_cnt2", int'(bus2.contagem), 3);

    // Random stream
    do_reset();
    ov_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) ov_r = ~ov_r;
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 99) == 0,
          P'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 7,
          1'($urandom_range(0, 1)),
          ov_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
